// File: rtl/circle_pkg.sv
// Shared constants and types for the midpoint circle rasteriser.
package circle_pkg;

    // Default visible framebuffer size
    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;

    // Signed width of computed point coordinates and offsets (covers -255..510)
    localparam int COORD_W = 10;

    // Signed width of the midpoint decision variable
    localparam int CRIT_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        INIT,
        PLOT,
        DONE
    } state_t;

endpackage

// File: rtl/circle_octant_pt.sv
// Maps the current octant offset pair onto one screen point and flags whether
// that point lies inside the visible framebuffer.
module circle_octant_pt
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic [7:0]                cx,
    input  logic [6:0]                cy,
    input  logic signed [COORD_W-1:0] ox,
    input  logic signed [COORD_W-1:0] oy,
    input  logic [2:0]                oct,
    output logic [7:0]                x,
    output logic [6:0]                y,
    output logic                      in_bounds
);

    localparam logic signed [COORD_W-1:0] X_LIM = COORD_W'(SCREEN_W);
    localparam logic signed [COORD_W-1:0] Y_LIM = COORD_W'(SCREEN_H);

    logic signed [COORD_W-1:0] cx_s;
    logic signed [COORD_W-1:0] cy_s;
    logic signed [COORD_W-1:0] px;
    logic signed [COORD_W-1:0] py;

    assign cx_s = $signed({2'b00, cx});
    assign cy_s = $signed({3'b000, cy});

    // Select the mirrored point for this octant, in fixed drawing order
    always_comb begin
        px = cx_s + ox;
        py = cy_s + oy;
        case (oct)
            3'd0: begin px = cx_s + ox; py = cy_s + oy; end
            3'd1: begin px = cx_s + oy; py = cy_s + ox; end
            3'd2: begin px = cx_s - ox; py = cy_s + oy; end
            3'd3: begin px = cx_s - oy; py = cy_s + ox; end
            3'd4: begin px = cx_s - ox; py = cy_s - oy; end
            3'd5: begin px = cx_s - oy; py = cy_s - ox; end
            3'd6: begin px = cx_s + ox; py = cy_s - oy; end
            default: begin px = cx_s + oy; py = cy_s - ox; end
        endcase
    end

    // Negative coordinates show up as a set sign bit
    assign in_bounds = !px[COORD_W-1] && (px < X_LIM) &&
                       !py[COORD_W-1] && (py < Y_LIM);

    assign x = px[7:0];
    assign y = py[6:0];

endmodule

// File: rtl/circle_drawer.sv
// Midpoint circle rasteriser: latches centre/radius/colour on request, then
// emits one octant point per cycle (clipped to the screen) until the octant
// sweep completes, and finally holds done until start is released.
module circle_drawer
    import circle_pkg::*;
#(
    parameter int SCREEN_W = SCREEN_W_DEFAULT,
    parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [2:0] colour,
    input  logic [7:0] centre_x,
    input  logic [6:0] centre_y,
    input  logic [7:0] radius,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic signed [CRIT_W-1:0]  CRIT_ONE  = CRIT_W'(1);
    localparam logic signed [COORD_W-1:0] COORD_ONE = COORD_W'(1);

    state_t                    state_reg, state_next;
    logic [2:0]                oct_reg, oct_next;
    logic [7:0]                cx_reg, cx_next;
    logic [6:0]                cy_reg, cy_next;
    logic [2:0]                colour_reg, colour_next;
    logic signed [COORD_W-1:0] ox_reg, ox_next;
    logic signed [COORD_W-1:0] oy_reg, oy_next;
    logic signed [CRIT_W-1:0]  crit_reg, crit_next;

    // Midpoint step evaluated once per octant sweep
    logic                      crit_le0;
    logic signed [COORD_W-1:0] oy_inc;
    logic signed [COORD_W-1:0] ox_dec;
    logic signed [COORD_W-1:0] step;
    logic signed [CRIT_W-1:0]  step_ext;
    logic signed [CRIT_W-1:0]  crit_upd;

    assign crit_le0 = crit_reg[CRIT_W-1] || (crit_reg == '0);
    assign oy_inc   = oy_reg + COORD_ONE;
    assign ox_dec   = crit_le0 ? ox_reg : (ox_reg - COORD_ONE);
    assign step     = crit_le0 ? oy_inc : (oy_inc - ox_dec);
    assign step_ext = CRIT_W'(step);
    assign crit_upd = crit_reg + (step_ext <<< 1) + CRIT_ONE;

    logic [7:0] pt_x;
    logic [6:0] pt_y;
    logic       pt_in_bounds;

    circle_octant_pt #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_octant_pt (
        .cx        (cx_reg),
        .cy        (cy_reg),
        .ox        (ox_reg),
        .oy        (oy_reg),
        .oct       (oct_reg),
        .x         (pt_x),
        .y         (pt_y),
        .in_bounds (pt_in_bounds)
    );

    // State and datapath registers; reset abandons any drawing in progress
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            oct_reg    <= '0;
            cx_reg     <= '0;
            cy_reg     <= '0;
            colour_reg <= '0;
            ox_reg     <= '0;
            oy_reg     <= '0;
            crit_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            oct_reg    <= oct_next;
            cx_reg     <= cx_next;
            cy_reg     <= cy_next;
            colour_reg <= colour_next;
            ox_reg     <= ox_next;
            oy_reg     <= oy_next;
            crit_reg   <= crit_next;
        end
    end

    // Next-state logic: latch on INIT, advance octant in PLOT, step the
    // midpoint variables after the eighth octant
    always_comb begin
        state_next  = state_reg;
        oct_next    = oct_reg;
        cx_next     = cx_reg;
        cy_next     = cy_reg;
        colour_next = colour_reg;
        ox_next     = ox_reg;
        oy_next     = oy_reg;
        crit_next   = crit_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = INIT;
                end
            end
            INIT: begin
                cx_next     = centre_x;
                cy_next     = centre_y;
                colour_next = colour;
                ox_next     = $signed({2'b00, radius});
                oy_next     = '0;
                crit_next   = CRIT_ONE - $signed({3'b000, radius});
                oct_next    = '0;
                state_next  = PLOT;
            end
            PLOT: begin
                if (oct_reg != 3'd7) begin
                    oct_next = oct_reg + 3'd1;
                end else begin
                    oct_next   = '0;
                    oy_next    = oy_inc;
                    ox_next    = ox_dec;
                    crit_next  = crit_upd;
                    state_next = (oy_inc <= ox_dec) ? PLOT : DONE;
                end
            end
            DONE: begin
                if (!start) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pixel outputs are only meaningful while plotting; park them at zero otherwise
    always_comb begin
        vga_plot   = 1'b0;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        done       = (state_reg == DONE);
        if (state_reg == PLOT) begin
            vga_plot   = pt_in_bounds;
            vga_x      = pt_x;
            vga_y      = pt_y;
            vga_colour = colour_reg;
        end
    end

endmodule

// File: doc/circle_drawer.md
# circle_drawer

Hardware circle rasteriser for the VGA adapter path: accepts centre, radius and colour, then walks the midpoint (Bresenham) circle algorithm and emits one pixel write per cycle to the 160×120 framebuffer adapter. It is the responder side of the top-level start/done handshake: the top level drives `start` and waits for `done`, and `circle_drawer` does the drawing. Off-screen points are clipped.

## Interface
- `SCREEN_W`, default 160: visible columns.
- `SCREEN_H`, default 120: visible rows.
- `clk`  in  1: system clock, CLOCK_50 at top.
- `rst_n`  in  1: asynchronous, active-low reset (KEY[3] at top).
- `start`  in  1: level request; held high until `done` is seen.
- `colour`  in  3: pixel colour.
- `centre_x`  in  8: centre column.
- `centre_y`  in  7: centre row.
- `radius`  in  8: radius in pixels.
- `done`  out  1: drawing complete; held while `start` is high.
- `vga_x`  out  8: pixel column.
- `vga_y`  out  7: pixel row.
- `vga_colour`  out  3: pixel colour.
- `vga_plot`  out  1: write strobe, one pixel per cycle.

## Operation
- States:
  - IDLE: waiting for `start`.
  - INIT: latch inputs.
  - PLOT: oct = 0..7.
  - DONE: holding `done` until `start` falls.
- IDLE → INIT when `start` = 1.
- INIT (1 cycle):
  - Latch `colour`, `centre_x`, `centre_y`, `radius`.
  - Initialise `ox` = radius, `oy` = 0, `crit` = 1 − radius.
  - Input changes after INIT are ignored.
- PLOT: one octant point per cycle, in this order:
  - (cx+ox, cy+oy)
  - (cx+oy, cy+ox)
  - (cx−ox, cy+oy)
  - (cx−oy, cy+ox)
  - (cx−ox, cy−oy)
  - (cx−oy, cy−ox)
  - (cx+ox, cy−oy)
  - (cx+oy, cy−ox)
- Update on the oct = 7 cycle:
  - `oy` += 1.
  - If `crit` ≤ 0: `crit` += 2·oy_new + 1.
  - Else: `ox` −= 1, then `crit` += 2·(oy_new − ox_new) + 1.
  - If oy_new ≤ ox_new: go to PLOT with oct = 0. Otherwise go to DONE.
- Arithmetic widths:
  - Point coordinates are computed signed, 10 bits.
  - `crit` is signed, 11 bits; there is no overflow for radius ≤ 255.
- Clipping: `vga_plot` = 1 only if 0 ≤ x < SCREEN_W and 0 ≤ y < SCREEN_H. Clipped cycles are still consumed, so timing is data-independent of position.
- `vga_x`/`vga_y` carry the low bits of the point; they are don't-care when `vga_plot` = 0.
- Duplicate points (e.g. radius 0, or the oy = ox diagonal) are plotted again, not suppressed.
- DONE:
  - `done` = 1.
  - When `start` = 0, go to IDLE next cycle.
  - If `start` is already low on DONE entry, `done` is high for exactly 1 cycle.
  - A new request needs `start` low for at least one cycle.
- Reset at any time: asynchronous return to IDLE; drawing is abandoned and no further plots occur.

## Timing
- Reset values: `done` = 0, `vga_plot` = 0, `vga_x` = 0, `vga_y` = 0, `vga_colour` = 0, state IDLE.
- `vga_*` outputs are combinational from registered state/offsets/latched inputs. They are valid throughout each PLOT cycle and sampled by the adapter at its end.
- Latency:
  - `start` seen in IDLE → INIT next edge.
  - First plot cycle follows INIT.
  - With N iterations, plot cycles = 8·N.
  - `done` rises the cycle after the last plot.
  - Total from `start` edge to `done` = 2 + 8·N cycles.
- `vga_plot` = 0 in IDLE, INIT and DONE.

## Structure
- Package `circle_pkg` holds:
  - `SCREEN_W`/`SCREEN_H` defaults.
  - `state_t` enum: IDLE, INIT, PLOT, DONE.
  - Coordinate/`crit` width constants.
- Sub-module `circle_octant_pt` (combinational) maps (cx, cy, ox, oy, oct) to (x, y, in_bounds).
- FSM, offset registers and `crit` update live in `circle_drawer`.

## Test plan
- Radius 0, centre (80, 60), colour 3, `start` held: 8 plots, all at (80, 60), colour 3; `done` 10 cycles after the `start` edge.
- Radius 1, centre (80, 60):
  - 16 plot cycles.
  - Pixel set {(81,60), (79,60), (80,61), (80,59), (81,61), (79,61), (81,59), (79,59)}.
  - `done` at cycle 18.
- Radius 10, centre (0, 0):
  - Only points with x ≥ 0 and y ≥ 0 are plotted; no plot with x > 10 or y > 10.
  - Total cycle count is unchanged versus a centred circle of radius 10.
- Handshake:
  - `done` stays high while `start` stays high 20 cycles; it drops one cycle after `start` falls.
  - Re-raising `start` draws again with newly latched inputs.
- Changing `radius`/`colour` mid-draw: the output pixel set matches the values latched at INIT.
- `rst_n` pulsed low mid-PLOT: `vga_plot`/`done` go to 0 immediately (asynchronously). With `start` low afterwards, there are no further plots.
